// File: rtl/mealy_event_logger.sv
// ---------------------------------------------------------------------------
// mealy_event_logger
//
// Downstream stage of the Mealy pattern detector. Every clock it samples the
// 2-bit hit vector, keeps a saturating count per pattern, and pushes each
// non-zero hit together with a free-running timestamp into a small FIFO that
// a consumer drains through a valid/ready handshake. A sticky flag records
// events lost because the FIFO was full.
//
// Parameters
//   DEPTH : FIFO entries (power of two, >= 2)
//   TW    : timestamp width
//   CW    : per-pattern counter width
//
// Ports
//   clock    in   rising-edge system clock
//   reset_n  in   asynchronous active-low reset
//   hit      in   [1:0] detector output (bit1 = "111", bit0 = "001")
//   clear    in   synchronous clear of counters, FIFO, overflow, timestamp
//   rd_valid out  head entry available
//   rd_ready in   consumer accepts the head entry
//   rd_kind  out  [1:0] hit vector of the head entry
//   rd_time  out  [TW-1:0] timestamp of the head entry
//   count_hi out  [CW-1:0] saturating count of bit1 events
//   count_lo out  [CW-1:0] saturating count of bit0 events
//   level    out  [clog2(DEPTH):0] FIFO occupancy
//   overflow out  sticky: an event was dropped
// ---------------------------------------------------------------------------
module mealy_event_logger #(
  parameter int DEPTH = 4,
  parameter int TW    = 8,
  parameter int CW    = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [1:0]               hit,
  input  logic                     clear,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [1:0]               rd_kind,
  output logic [TW-1:0]            rd_time,
  output logic [CW-1:0]            count_hi,
  output logic [CW-1:0]            count_lo,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
  localparam logic [PW-1:0] PTR_ONE    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TS_ONE     = {{(TW-1){1'b0}}, 1'b1};

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt, input logic step);
    logic [CW-1:0] res;
    if (step && (cnt != CNT_MAX)) begin
      res = cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  logic [TW-1:0] ts_r;
  logic [CW-1:0] cnt_hi_r;
  logic [CW-1:0] cnt_lo_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic          ovf_r;
  logic [1:0]    mem_kind_r [DEPTH];
  logic [TW-1:0] mem_time_r [DEPTH];

  logic [PW-1:0] level_s;
  logic          valid_s;
  logic          pop_s;
  logic          event_s;
  logic          full_s;
  logic          push_s;
  logic [1:0]    head_kind_s;
  logic [TW-1:0] head_time_s;

  // FIFO status, handshake decode and combinational head read.
  always_comb begin
    level_s     = wr_ptr_r - rd_ptr_r;
    valid_s     = (level_s != {PW{1'b0}});
    pop_s       = valid_s && rd_ready;
    event_s     = (hit != 2'b00);
    full_s      = (level_s == FULL_LEVEL);
    // A full FIFO still accepts an event when the head leaves on the same edge.
    push_s      = event_s && (!full_s || pop_s);
    head_kind_s = 2'b00;
    head_time_s = {TW{1'b0}};
    if (valid_s) begin
      head_kind_s = mem_kind_r[rd_ptr_r[AW-1:0]];
      head_time_s = mem_time_r[rd_ptr_r[AW-1:0]];
    end else begin
      head_kind_s = 2'b00;
      head_time_s = {TW{1'b0}};
    end
  end

  // Timestamp, counters, pointers and sticky overflow; clear outranks events and pops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_r     <= {TW{1'b0}};
      cnt_hi_r <= {CW{1'b0}};
      cnt_lo_r <= {CW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      ovf_r    <= 1'b0;
    end else if (clear) begin
      ts_r     <= {TW{1'b0}};
      cnt_hi_r <= {CW{1'b0}};
      cnt_lo_r <= {CW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      ts_r     <= ts_r + TS_ONE;
      // Dropped events are still counted.
      cnt_hi_r <= sat_inc(cnt_hi_r, hit[1]);
      cnt_lo_r <= sat_inc(cnt_lo_r, hit[0]);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (event_s && !push_s) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // Entry storage; written with {hit, ts} sampled at the event edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_kind_r[i] <= 2'b00;
        mem_time_r[i] <= {TW{1'b0}};
      end
    end else if (push_s && !clear) begin
      mem_kind_r[wr_ptr_r[AW-1:0]] <= hit;
      mem_time_r[wr_ptr_r[AW-1:0]] <= ts_r;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_kind_r[i] <= mem_kind_r[i];
        mem_time_r[i] <= mem_time_r[i];
      end
    end
  end

  // Output mapping: status and counters come straight from registers.
  always_comb begin
    rd_valid = valid_s;
    rd_kind  = head_kind_s;
    rd_time  = head_time_s;
    count_hi = cnt_hi_r;
    count_lo = cnt_lo_r;
    level    = level_s;
    overflow = ovf_r;
  end

endmodule

// File: tb/tb_mealy_event_logger.sv
// ---------------------------------------------------------------------------
// tb_mealy_event_logger
//
// Drives two instances with identical stimulus: A uses the default widths
// (DEPTH=4, TW=8, CW=8), B uses narrow ones (DEPTH=4, TW=4, CW=2) so that
// timestamp wrap and counter saturation are reachable. A queue-based model
// with unbounded integer time and counts predicts both; widths are applied
// only when comparing. Directed scenarios carry hand-computed expectations,
// followed by a randomized run with occasional clears and async resets.
// ---------------------------------------------------------------------------
module tb_mealy_event_logger;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] hit = 2'b00;
  logic       clear = 1'b0;
  logic       rd_ready = 1'b0;

  logic       a_valid, b_valid;
  logic [1:0] a_kind, b_kind;
  logic [7:0] a_time;
  logic [3:0] b_time;
  logic [7:0] a_hi, a_lo;
  logic [1:0] b_hi, b_lo;
  logic [2:0] a_level, b_level;
  logic       a_ovf, b_ovf;

  int checks = 0;
  int failures = 0;

  mealy_event_logger dut_a (
    .clock(clock), .reset_n(reset_n), .hit(hit), .clear(clear),
    .rd_valid(a_valid), .rd_ready(rd_ready), .rd_kind(a_kind), .rd_time(a_time),
    .count_hi(a_hi), .count_lo(a_lo), .level(a_level), .overflow(a_ovf)
  );

  mealy_event_logger #(.DEPTH(4), .TW(4), .CW(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .hit(hit), .clear(clear),
    .rd_valid(b_valid), .rd_ready(rd_ready), .rd_kind(b_kind), .rd_time(b_time),
    .count_hi(b_hi), .count_lo(b_lo), .level(b_level), .overflow(b_ovf)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0] kind;
    int         t;
  } ent_t;

  ent_t mq[$];
  int   m_ts = 0;
  int   m_hi = 0;
  int   m_lo = 0;
  bit   m_ovf = 1'b0;
  int   m_sz;
  bit   m_pop;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n || (clear === 1'b1)) begin
      m_ts = 0; m_hi = 0; m_lo = 0; m_ovf = 1'b0;
      mq.delete();
    end else begin
      m_sz  = mq.size();
      m_pop = (m_sz != 0) && rd_ready;
      if (m_pop) void'(mq.pop_front());
      if (hit != 2'b00) begin
        m_hi += int'(hit[1]);
        m_lo += int'(hit[0]);
        if (m_sz < 4 || m_pop) mq.push_back('{hit, m_ts});
        else m_ovf = 1'b1;
      end
      m_ts++;
    end
  end

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    logic       e_valid;
    logic [1:0] e_kind;
    int         e_t;
    e_valid = (mq.size() != 0);
    e_kind  = e_valid ? mq[0].kind : 2'b00;
    e_t     = e_valid ? mq[0].t : 0;
    chk("a_valid", 32'(a_valid), 32'(e_valid));
    chk("a_kind",  32'(a_kind),  32'(e_kind));
    chk("a_time",  32'(a_time),  32'(e_t % 256));
    chk("a_hi",    32'(a_hi),    32'(sat(m_hi, 255)));
    chk("a_lo",    32'(a_lo),    32'(sat(m_lo, 255)));
    chk("a_level", 32'(a_level), 32'(mq.size()));
    chk("a_ovf",   32'(a_ovf),   32'(m_ovf));
    chk("b_valid", 32'(b_valid), 32'(e_valid));
    chk("b_kind",  32'(b_kind),  32'(e_kind));
    chk("b_time",  32'(b_time),  32'(e_t % 16));
    chk("b_hi",    32'(b_hi),    32'(sat(m_hi, 3)));
    chk("b_lo",    32'(b_lo),    32'(sat(m_lo, 3)));
    chk("b_level", 32'(b_level), 32'(mq.size()));
    chk("b_ovf",   32'(b_ovf),   32'(m_ovf));
  end

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge: drive inputs, let one rising edge pass, return at the next falling edge.
  task automatic cyc(input logic [1:0] h, input logic r, input logic c);
    hit = h; rd_ready = r; clear = c;
    @(negedge clock);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_valid"}, 32'({a_valid, b_valid}), 32'd0);
    chk({tag, "_kind"},  32'({a_kind, b_kind}),   32'd0);
    chk({tag, "_time"},  32'({a_time, b_time}),   32'd0);
    chk({tag, "_cnt"},   32'({a_hi, a_lo, b_hi, b_lo}), 32'd0);
    chk({tag, "_level"}, 32'({a_level, b_level}), 32'd0);
    chk({tag, "_ovf"},   32'({a_ovf, b_ovf}),     32'd0);
  endtask

  // Mid-cycle asynchronous reset, checked before the next edge, released at a falling edge.
  task automatic mid_reset(input string tag);
    hit = 2'b00; rd_ready = 1'b0; clear = 1'b0;
    #2 reset_n = 1'b0;
    #1 all_zero(tag);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Idle after release.
    repeat (10) cyc(2'b00, 1'b0, 1'b0);
    all_zero("idle");

    // Detector pattern stream: events at ts 2, 6, 9.
    mid_reset("rst0");
    for (int i = 0; i < 10; i++)
      cyc((i == 2) ? 2'b01 : ((i == 6 || i == 9) ? 2'b10 : 2'b00), 1'b0, 1'b0);
    chk("pat_lo", 32'(a_lo), 32'd1);
    chk("pat_hi", 32'(a_hi), 32'd2);
    chk("pat_level", 32'(a_level), 32'd3);
    chk("pop0_kind", 32'(a_kind), 32'd1);
    chk("pop0_time", 32'(a_time), 32'd2);
    cyc(2'b00, 1'b1, 1'b0);
    chk("pop1_kind", 32'(a_kind), 32'd2);
    chk("pop1_time", 32'(a_time), 32'd6);
    cyc(2'b00, 1'b1, 1'b0);
    chk("pop2_kind", 32'(a_kind), 32'd2);
    chk("pop2_time", 32'(a_time), 32'd9);
    cyc(2'b00, 1'b1, 1'b0);
    chk("pop_empty", 32'(a_valid), 32'd0);

    // Async reset with three entries queued.
    repeat (3) cyc(2'b01, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(a_level), 32'd3);
    mid_reset("rst3");

    // Overflow: five consecutive bit1 events with no consumer.
    repeat (5) cyc(2'b10, 1'b0, 1'b0);
    chk("ovf_level", 32'(a_level), 32'd4);
    chk("ovf_flag", 32'(a_ovf), 32'd1);
    chk("ovf_hi_a", 32'(a_hi), 32'd5);
    chk("ovf_hi_b", 32'(b_hi), 32'd3);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_time", 32'(a_time), 32'(k));
      cyc(2'b00, 1'b1, 1'b0);
    end
    chk("ovf_sticky", 32'(a_ovf), 32'd1);

    // Full FIFO with simultaneous event and pop.
    cyc(2'b00, 1'b0, 1'b1);
    repeat (4) cyc(2'b10, 1'b0, 1'b0);
    cyc(2'b01, 1'b1, 1'b0);
    chk("fullsim_level", 32'(a_level), 32'd4);
    chk("fullsim_ovf", 32'(a_ovf), 32'd0);
    repeat (3) cyc(2'b00, 1'b1, 1'b0);
    chk("fullsim_last_kind", 32'(a_kind), 32'd1);
    chk("fullsim_last_time", 32'(a_time), 32'd4);

    // Timestamp wrap on the 4-bit instance.
    cyc(2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 18; i++)
      cyc((i == 14 || i == 17) ? 2'b10 : 2'b00, 1'b0, 1'b0);
    chk("wrap_b0", 32'(b_time), 32'd14);
    chk("wrap_a0", 32'(a_time), 32'd14);
    cyc(2'b00, 1'b1, 1'b0);
    chk("wrap_b1", 32'(b_time), 32'd1);
    chk("wrap_a1", 32'(a_time), 32'd17);

    // Counter saturation on the 2-bit instance.
    cyc(2'b00, 1'b1, 1'b1);
    repeat (6) cyc(2'b10, 1'b1, 1'b0);
    chk("sat_b", 32'(b_hi), 32'd3);
    chk("sat_a", 32'(a_hi), 32'd6);

    // Clear outranks a simultaneous event and pop.
    cyc(2'b00, 1'b0, 1'b1);
    cyc(2'b10, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0);
    chk("clr_pre_level", 32'(a_level), 32'd2);
    cyc(2'b11, 1'b1, 1'b1);
    chk("clr_level", 32'(a_level), 32'd0);
    chk("clr_cnt", 32'({a_hi, a_lo}), 32'd0);
    chk("clr_ovf", 32'(a_ovf), 32'd0);
    cyc(2'b01, 1'b0, 1'b0);
    chk("clr_ts", 32'(a_time), 32'd0);
    chk("clr_lo", 32'(a_lo), 32'd1);

    // Randomized run against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        mid_reset("rnd_rst");
      end else begin
        cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
